// File: rtl/note_switch_debouncer.sv
// Debounces the four board switches (play enable + 3-bit note select) feeding the
// display and tone path. Optional glitch counter output enabled by DEBOUNCE_GLITCH_CNT_EN.
module note_switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_raw,
    output logic [3:0] sw,
    output logic       note_change,
    output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [3:0] sync;

    // Two-flop synchroniser per switch bit; each bit is asynchronous to the others.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= sw_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync[gi] = sync_reg;
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [3:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       sw_reg, sw_next;
    logic             note_change_reg, note_change_next;
    logic             busy_reg, busy_next;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic             glitch_ev;
    logic [7:0]       glitch_cnt_reg, glitch_cnt_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= STABLE;
            cand_reg        <= 4'b0000;
            cnt_reg         <= '0;
            sw_reg          <= 4'b0000;
            note_change_reg <= 1'b0;
            busy_reg        <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            glitch_cnt_reg  <= 8'd0;
`endif
        end else begin
            state_reg       <= state_next;
            cand_reg        <= cand_next;
            cnt_reg         <= cnt_next;
            sw_reg          <= sw_next;
            note_change_reg <= note_change_next;
            busy_reg        <= busy_next;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            glitch_cnt_reg  <= glitch_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        cand_next        = cand_reg;
        cnt_next         = cnt_reg;
        sw_next          = sw_reg;
        note_change_next = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        glitch_ev        = 1'b0;
`endif
        case (state_reg)
            STABLE: begin
                if (sync != sw_reg) begin
                    cand_next  = sync;
                    cnt_next   = '0;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                // cand never equals sw here, so the three branches are disjoint.
                if (sync == cand_reg) begin
                    if (cnt_reg == CNT_MAX) begin
                        sw_next          = cand_reg;
                        note_change_next = 1'b1;
                        state_next       = STABLE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else if (sync == sw_reg) begin
                    state_next = STABLE;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                    glitch_ev  = 1'b1;
`endif
                end else begin
                    cand_next = sync;
                    cnt_next  = '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                    glitch_ev = 1'b1;
`endif
                end
            end
            default: begin
                state_next = STABLE;
            end
        endcase
        busy_next = (state_next == PENDING);
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    always_comb begin
        glitch_cnt_next = glitch_cnt_reg;
        if (glitch_ev && (glitch_cnt_reg != 8'd255)) begin
            glitch_cnt_next = glitch_cnt_reg + 8'd1;
        end
    end

    assign glitch_cnt = glitch_cnt_reg;
`endif

    assign sw          = sw_reg;
    assign note_change = note_change_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_note_switch_debouncer.sv
// Directed bench for note_switch_debouncer with DEBOUNCE_CYCLES=4 (commit 7 cycles after a raw change).
module tb_note_switch_debouncer;

    localparam int DC = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_raw;
    logic [3:0] sw;
    logic       note_change;
    logic       busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int nc_count = 0;
    int nc_double = 0;
    logic nc_prev = 1'b0;
    int nc_before;

    note_switch_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .sw(sw),
        .note_change(note_change),
        .busy(busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (note_change) nc_count <= nc_count + 1;
        if (note_change && nc_prev) nc_double <= nc_double + 1;
        nc_prev <= note_change;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sw_raw = 4'b0000;
        step(3);
        check("rst_sw", {28'd0, sw}, 32'h0);
        check("rst_nc", {31'd0, note_change}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("rst_glitch", {24'd0, glitch_cnt}, 32'h0);
`endif
        rst_n = 1'b1;
        step(4);

        // Basic qualification: commit exactly 7 cycles after the change.
        sw_raw = 4'b0011;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check($sformatf("basic_busy_c%0d", k), {31'd0, busy}, (k >= 3 && k <= 6) ? 32'h1 : 32'h0);
            check($sformatf("basic_sw_c%0d", k), {28'd0, sw}, (k == 7) ? 32'h3 : 32'h0);
            check($sformatf("basic_nc_c%0d", k), {31'd0, note_change}, (k == 7) ? 32'h1 : 32'h0);
        end
        step(1);
        check("basic_nc_drop", {31'd0, note_change}, 32'h0);
        check("basic_sw_hold", {28'd0, sw}, 32'h3);

        // Short excursion that bounces back to the committed code.
        nc_before = nc_count;
        sw_raw = 4'b0101;
        step(2);
        sw_raw = 4'b0011;
        step(12);
        check("bounce_sw", {28'd0, sw}, 32'h3);
        check("bounce_nc", nc_count, nc_before);
        check("bounce_busy", {31'd0, busy}, 32'h0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("bounce_glitch", {24'd0, glitch_cnt}, 32'h1);
`endif

        // Candidate replaced mid-qualification: direct 0011 -> 0111.
        nc_before = nc_count;
        sw_raw = 4'b0101;
        step(2);
        sw_raw = 4'b0111;
        step(6);
        check("reload_sw_early", {28'd0, sw}, 32'h3);
        step(1);
        check("reload_sw", {28'd0, sw}, 32'h7);
        check("reload_nc", {31'd0, note_change}, 32'h1);
        step(3);
        check("reload_nc_once", nc_count, nc_before + 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("reload_glitch", {24'd0, glitch_cnt}, 32'h2);
`endif

        // Reset mid-PENDING, then requalify after release.
        nc_before = nc_count;
        sw_raw = 4'b1111;
        step(4);
        check("midrst_busy_pre", {31'd0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_sw_async", {28'd0, sw}, 32'h0);
        check("midrst_busy_async", {31'd0, busy}, 32'h0);
        step(2);
        check("midrst_nc_none", nc_count, nc_before);
        rst_n = 1'b1;
        step(6);
        check("midrst_sw_early", {28'd0, sw}, 32'h0);
        step(1);
        check("midrst_sw", {28'd0, sw}, 32'hF);
        check("midrst_nc", {31'd0, note_change}, 32'h1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("midrst_glitch", {24'd0, glitch_cnt}, 32'h0);
`endif
        step(2);

        // Bit 0 chatter every cycle never commits.
        nc_before = nc_count;
        for (int i = 0; i < 50; i++) begin
            sw_raw[0] = ~sw_raw[0];
            step(1);
        end
        step(6);
        check("chatter_sw", {28'd0, sw}, 32'hF);
        check("chatter_nc", nc_count, nc_before);
        check("chatter_busy", {31'd0, busy}, 32'h0);

        // Long chatter run to saturate the glitch counter.
        for (int i = 0; i < 600; i++) begin
            sw_raw[0] = ~sw_raw[0];
            step(1);
        end
        step(6);
        check("long_sw", {28'd0, sw}, 32'hF);
        check("long_nc", nc_count, nc_before);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("long_glitch_sat", {24'd0, glitch_cnt}, 32'hFF);
`endif

        // Single-bit change on bit 0 alone qualifies like any other.
        nc_before = nc_count;
        sw_raw = 4'b1110;
        step(6);
        check("bit0_sw_early", {28'd0, sw}, 32'hF);
        step(1);
        check("bit0_sw", {28'd0, sw}, 32'hE);
        check("bit0_nc", {31'd0, note_change}, 32'h1);
        step(3);
        check("bit0_nc_once", nc_count, nc_before + 1);
        check("nc_never_double", nc_double, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_switch_debouncer.md
NOTE_SWITCH_DEBOUNCER -- requirements
Module: note_switch_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable cycles required to accept a new switch code (20 ms at 50 MHz); legal range 2 to 2^24.
REQ-002 The block SHALL have parameter CNT_W, default 20, meaning the stability counter width; it SHALL be wide enough to hold DEBOUNCE_CYCLES-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state advances on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port sw_raw, input, 4 bits: the asynchronous board switches; [0] is play enable and [3:1] is note select.
REQ-006 The block SHALL have port sw, output, 4 bits: the debounced code that feeds the hex display controller and the tone generator.
REQ-007 The block SHALL have port note_change, output, 1 bit: a one-cycle pulse on every sw update.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a candidate code is being qualified.

Function
REQ-009 The block SHALL pass sw_raw through a 2-flop synchroniser per bit, producing sync; sw_raw is never used directly.
REQ-010 The block SHALL implement an FSM with states STABLE and PENDING, plus a candidate register cand[3:0] and a counter cnt[CNT_W-1:0].
REQ-011 In STABLE, when sync differs from sw, the block SHALL load cand from sync, clear cnt and go to PENDING; otherwise it SHALL hold.
REQ-012 In PENDING with sync equal to cand and cnt below DEBOUNCE_CYCLES-1, the block SHALL increment cnt.
REQ-013 In PENDING with sync equal to cand and cnt equal to DEBOUNCE_CYCLES-1, the block SHALL load sw from cand, pulse note_change for exactly one cycle and return to STABLE.
REQ-014 In PENDING with sync equal to sw (bounce back to the old code), the block SHALL return to STABLE, leave sw unchanged and not pulse note_change.
REQ-015 In PENDING with sync differing from both cand and sw, the block SHALL reload cand from sync, clear cnt and stay in PENDING.
REQ-016 The latency from a sw_raw change held steady to the update of sw SHALL be exactly DEBOUNCE_CYCLES+3 clk cycles.
REQ-017 A change on any single bit, including sw_raw[0] alone, SHALL be qualified identically.
REQ-018 cnt SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1 only for the commit cycle.
REQ-019 busy SHALL equal (state == PENDING), registered.
REQ-020 note_change SHALL never be asserted in two consecutive cycles.

Reset
REQ-021 While rst_n is low, the block SHALL immediately force synchroniser flops to 0, sw to 4'b0000 (silent, idle display), cand to 0, cnt to 0, note_change to 0, busy to 0 and state to STABLE.
REQ-022 Asserting reset mid-PENDING SHALL discard the candidate with no note_change.
REQ-023 After rst_n deasserts, a nonzero sw_raw SHALL be qualified as a normal change.

Configuration
REQ-024 When DEBOUNCE_GLITCH_CNT_EN is defined, the block SHALL add output glitch_cnt[7:0] (reset 0), which increments on each REQ-014 or REQ-015 event and saturates at 255.
REQ-025 When DEBOUNCE_GLITCH_CNT_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, then sw_raw 0000 to 0011 held: sw=0011 exactly 7 cycles after the change, with note_change high for 1 cycle and busy high for the preceding 4 cycles.
REQ-027 From sw=0011, sw_raw pulses 0101 for 2 cycles then returns to 0011: sw stays 0011, no note_change, and glitch_cnt=1 if DEBOUNCE_GLITCH_CNT_EN is defined.
REQ-028 sw_raw 0011, then 0101 after 2 cycles, then 0111 after 2 more cycles and held: sw goes directly from 0011 to 0111 with a single note_change.
REQ-029 With sw_raw 1111 held and rst_n pulsed low during PENDING: sw=0000 asynchronously, then sw=1111 7 cycles after rst_n rises.
REQ-030 sw_raw toggles bit 0 every cycle for 50 cycles: sw is unchanged, no note_change, and glitch_cnt saturation is checked with a long run of 600 cycles.
